// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad path: code width, the "no key" code,
// debounce FSM states and the key codes the vending controller interprets.
package keypad_pkg;

  localparam int KEY_W = 4;
  localparam logic [KEY_W-1:0] KEY_NONE = 4'h0;

  // Debounce FSM states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } key_state_t;

  // Key codes as produced by the 4x4 scanner (0 is reserved for "no key")
  localparam logic [KEY_W-1:0] KEY_1      = 4'h1;
  localparam logic [KEY_W-1:0] KEY_2      = 4'h2;
  localparam logic [KEY_W-1:0] KEY_3      = 4'h3;
  localparam logic [KEY_W-1:0] KEY_4      = 4'h4;
  localparam logic [KEY_W-1:0] KEY_5      = 4'h5;
  localparam logic [KEY_W-1:0] KEY_6      = 4'h6;
  localparam logic [KEY_W-1:0] KEY_7      = 4'h7;
  localparam logic [KEY_W-1:0] KEY_8      = 4'h8;
  localparam logic [KEY_W-1:0] KEY_9      = 4'h9;
  localparam logic [KEY_W-1:0] KEY_0      = 4'hA;
  localparam logic [KEY_W-1:0] KEY_STAR   = 4'hB;
  localparam logic [KEY_W-1:0] KEY_HASH   = 4'hC;
  localparam logic [KEY_W-1:0] KEY_CANCEL = 4'hD;
  localparam logic [KEY_W-1:0] KEY_ENTER  = 4'hE;
  localparam logic [KEY_W-1:0] KEY_COIN   = 4'hF;

  // True when the scanner reports any key at all
  function automatic logic is_pressed(input logic [KEY_W-1:0] code);
    return code != KEY_NONE;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Small event FIFO between the debouncer and the vending controller.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate occupancy counter. DEPTH must be a power of two >= 2.
module key_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             overflow
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             empty;
  logic             do_pop;
  logic             do_push;

  assign wr_idx = wr_ptr[IDX_W-1:0];
  assign rd_idx = rd_ptr[IDX_W-1:0];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_idx == rd_idx) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // still accepted when the consumer takes the head at the same time.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign valid = !empty;
  assign head  = mem[rd_idx];

  // Storage, pointers and the registered drop pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_idx] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      overflow <= push && full && !do_pop;
    end
  end

endmodule

// File: rtl/key_event_queue.sv
// Debounces the keypad scanner's level code into single press events and
// queues them for the vending controller over a valid/ready interface.
// Optional auto-repeat while a key is held: define KEY_REPEAT_EN.
module key_event_queue
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 4,
  parameter int REPEAT_CYCLES   = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [KEY_W-1:0] key_value,
  output logic             ev_valid,
  output logic [KEY_W-1:0] ev_code,
  input  logic             ev_ready,
  output logic             fifo_full,
  output logic             overflow
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  key_state_t       state;
  key_state_t       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [KEY_W-1:0] cand;
  logic [KEY_W-1:0] cand_next;
  logic [KEY_W-1:0] key_q;
  logic             db_push;
  logic             push;

  // Debounce state, counter, candidate code and the input sampling register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= KEY_NONE;
      key_q <= KEY_NONE;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      cand  <= cand_next;
      key_q <= key_value;
    end
  end

  // Next-state logic: a code must hold for DEBOUNCE_CYCLES to count as a
  // press or a release; one event is pushed when a press qualifies.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    cand_next  = cand;
    db_push    = 1'b0;
    case (state)
      IDLE: begin
        if (is_pressed(key_q)) begin
          state_next = PRESS_DB;
          cand_next  = key_q;
          cnt_next   = '0;
        end
      end
      PRESS_DB: begin
        if (key_q != cand) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = HELD;
          cnt_next   = '0;
          db_push    = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      HELD: begin
        // Another key rolled over while held is ignored until a release
        if (!is_pressed(key_q)) begin
          state_next = REL_DB;
          cnt_next   = '0;
        end
      end
      REL_DB: begin
        if (key_q == cand) begin
          state_next = HELD;
          cnt_next   = '0;
        end else if (is_pressed(key_q)) begin
          state_next = PRESS_DB;
          cand_next  = key_q;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

`ifdef KEY_REPEAT_EN
  localparam int RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_push;

  assign rpt_push = (state == HELD) && is_pressed(key_q) && (rpt_cnt == RPT_LAST);

  // Repeat timer runs only while staying in HELD; any exit clears it so a
  // return from REL_DB starts a fresh interval.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rpt_cnt <= '0;
    end else if ((state == HELD) && (state_next == HELD)) begin
      rpt_cnt <= (rpt_cnt == RPT_LAST) ? '0 : rpt_cnt + 1'b1;
    end else begin
      rpt_cnt <= '0;
    end
  end

  assign push = db_push | rpt_push;
`else
  // No repeat hardware in this build; the interval parameter is tied off
  // so it reads as deliberately unused.
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_CYCLES > 0);

  assign push = db_push;
`endif

  key_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KEY_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (cand),
    .pop       (ev_ready),
    .valid     (ev_valid),
    .head      (ev_code),
    .full      (fifo_full),
    .overflow  (overflow)
  );

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue with DEBOUNCE_CYCLES=4, FIFO_DEPTH=4,
// REPEAT_CYCLES=8. Inputs change and outputs are sampled 1ns after each
// rising edge; every applied vector is followed by one clock edge.
module tb_key_event_queue;

  localparam int DB = 4;

  logic       clk;
  logic       reset;
  logic [3:0] key_value;
  logic       ev_valid;
  logic [3:0] ev_code;
  logic       ev_ready;
  logic       fifo_full;
  logic       overflow;

  int vectors_applied;
  int miscompares;

  typedef struct {
    logic [3:0] key;
    logic       ready;
    logic       rst;
    logic       exp_valid;
    logic [3:0] exp_code;
    logic       exp_full;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[$];

  key_event_queue #(
    .DEBOUNCE_CYCLES (4),
    .FIFO_DEPTH      (4),
    .REPEAT_CYCLES   (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_value (key_value),
    .ev_valid  (ev_valid),
    .ev_code   (ev_code),
    .ev_ready  (ev_ready),
    .fifo_full (fifo_full),
    .overflow  (overflow)
  );

  // 10ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one input vector and let exactly one rising edge pass
  task automatic applyStimulus(input logic [3:0] key, input logic ready, input logic rst);
    key_value = key;
    ev_ready  = ready;
    reset     = rst;
    @(posedge clk);
    #1;
  endtask

  // Compare outputs; the code is only meaningful while an event is valid
  task automatic checkOutput(input string name, input logic exp_valid, input logic [3:0] exp_code,
                             input logic exp_full, input logic exp_ovf);
    vectors_applied++;
    if (ev_valid !== exp_valid || (exp_valid && ev_code !== exp_code) ||
        fifo_full !== exp_full || overflow !== exp_ovf) begin
      miscompares++;
      $display("[TB] FAIL %s: got valid=%b code=%h full=%b ovf=%b, expected valid=%b code=%h full=%b ovf=%b",
               name, ev_valid, ev_code, fifo_full, overflow, exp_valid, exp_code, exp_full, exp_ovf);
    end
  endtask

  task automatic addVec(input logic [3:0] key, input logic ready, input logic rst, input logic ev,
                        input logic [3:0] code, input logic full, input logic ovf);
    vec_t v;
    v.key = key; v.ready = ready; v.rst = rst;
    v.exp_valid = ev; v.exp_code = code; v.exp_full = full; v.exp_ovf = ovf;
    vecs.push_back(v);
  endtask

  task automatic releaseKey(input int n, input logic ready);
    for (int i = 0; i < n; i++) applyStimulus(4'h0, ready, 1'b1);
  endtask

  // Hold a code long enough to debounce; check the cycle the event lands
  task automatic pressKey(input logic [3:0] code, input logic ready, input logic [3:0] exp_head,
                          input logic exp_full, input logic exp_ovf, input string name);
    for (int i = 0; i < DB + 1; i++) applyStimulus(code, ready, 1'b1);
    applyStimulus(code, ready, 1'b1);
    checkOutput(name, 1'b1, exp_head, exp_full, exp_ovf);
  endtask

  initial begin
    int ev_count;
    vectors_applied = 0;
    miscompares     = 0;
    key_value = 4'h0;
    ev_ready  = 1'b1;
    reset     = 1'b0;

    // Reset, then key 3 stable: event visible only after the 6th edge
    addVec(4'h0, 1, 0, 0, 4'h0, 0, 0);
    for (int i = 0; i < 5; i++) addVec(4'h3, 1, 1, 0, 4'h0, 0, 0);
    addVec(4'h3, 1, 1, 1, 4'h3, 0, 0);
    for (int i = 0; i < 6; i++) addVec(4'h3, 1, 1, 0, 4'h0, 0, 0);
    for (int i = 0; i < 8; i++) addVec(4'h0, 1, 1, 0, 4'h0, 0, 0);
    // Bouncing 2/0 every 2 cycles never qualifies
    for (int r = 0; r < 5; r++) begin
      addVec(4'h2, 1, 1, 0, 4'h0, 0, 0);
      addVec(4'h2, 1, 1, 0, 4'h0, 0, 0);
      addVec(4'h0, 1, 1, 0, 4'h0, 0, 0);
      addVec(4'h0, 1, 1, 0, 4'h0, 0, 0);
    end
    for (int i = 0; i < 5; i++) addVec(4'h2, 1, 1, 0, 4'h0, 0, 0);
    addVec(4'h2, 1, 1, 1, 4'h2, 0, 0);
    for (int i = 0; i < 2; i++) addVec(4'h2, 1, 1, 0, 4'h0, 0, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].key, vecs[i].ready, vecs[i].rst);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_code,
                  vecs[i].exp_full, vecs[i].exp_ovf);
    end

    // Held 5 with a one-cycle release glitch: only the first press counts
    releaseKey(8, 1'b1);
    for (int i = 0; i < DB + 1; i++) begin
      applyStimulus(4'h5, 1'b1, 1'b1);
      checkOutput($sformatf("glitch_pre%0d", i), 1'b0, 4'h0, 1'b0, 1'b0);
    end
    applyStimulus(4'h5, 1'b1, 1'b1);
    checkOutput("glitch_first_event", 1'b1, 4'h5, 1'b0, 1'b0);
    applyStimulus(4'h5, 1'b1, 1'b1);
    applyStimulus(4'h0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'h5, 1'b1, 1'b1);
      checkOutput($sformatf("glitch_hold%0d", i), 1'b0, 4'h0, 1'b0, 1'b0);
    end
    releaseKey(8, 1'b1);
    pressKey(4'h5, 1'b1, 4'h5, 1'b0, 1'b0, "glitch_second_press");
    releaseKey(8, 1'b1);

    // Consumer stalled: four presses fill the FIFO, the fifth is dropped
    pressKey(4'h1, 1'b0, 4'h1, 1'b0, 1'b0, "fill_1"); releaseKey(7, 1'b0);
    pressKey(4'h2, 1'b0, 4'h1, 1'b0, 1'b0, "fill_2"); releaseKey(7, 1'b0);
    pressKey(4'h3, 1'b0, 4'h1, 1'b0, 1'b0, "fill_3"); releaseKey(7, 1'b0);
    pressKey(4'h4, 1'b0, 4'h1, 1'b1, 1'b0, "fill_4_full"); releaseKey(7, 1'b0);
    pressKey(4'h5, 1'b0, 4'h1, 1'b1, 1'b1, "drop_5_overflow");
    applyStimulus(4'h0, 1'b0, 1'b1);
    checkOutput("overflow_one_cycle", 1'b1, 4'h1, 1'b1, 1'b0);
    releaseKey(6, 1'b0);
    applyStimulus(4'h0, 1'b1, 1'b1); checkOutput("drain_2", 1'b1, 4'h2, 1'b0, 1'b0);
    applyStimulus(4'h0, 1'b1, 1'b1); checkOutput("drain_3", 1'b1, 4'h3, 1'b0, 1'b0);
    applyStimulus(4'h0, 1'b1, 1'b1); checkOutput("drain_4", 1'b1, 4'h4, 1'b0, 1'b0);
    applyStimulus(4'h0, 1'b1, 1'b1); checkOutput("drain_empty", 1'b0, 4'h0, 1'b0, 1'b0);
    releaseKey(4, 1'b1);

    // Full FIFO: push lands on the same edge as a pop, nothing dropped
    pressKey(4'h6, 1'b0, 4'h6, 1'b0, 1'b0, "pp_fill_6"); releaseKey(7, 1'b0);
    pressKey(4'h7, 1'b0, 4'h6, 1'b0, 1'b0, "pp_fill_7"); releaseKey(7, 1'b0);
    pressKey(4'h8, 1'b0, 4'h6, 1'b0, 1'b0, "pp_fill_8"); releaseKey(7, 1'b0);
    pressKey(4'h9, 1'b0, 4'h6, 1'b1, 1'b0, "pp_fill_9_full"); releaseKey(7, 1'b0);
    for (int i = 0; i < DB + 1; i++) applyStimulus(4'hA, 1'b0, 1'b1);
    applyStimulus(4'hA, 1'b1, 1'b1);
    checkOutput("pp_push_pop", 1'b1, 4'h7, 1'b1, 1'b0);
    applyStimulus(4'hA, 1'b0, 1'b1);
    checkOutput("pp_no_overflow", 1'b1, 4'h7, 1'b1, 1'b0);
    applyStimulus(4'h0, 1'b1, 1'b1); checkOutput("pp_drain_8", 1'b1, 4'h8, 1'b0, 1'b0);
    applyStimulus(4'h0, 1'b1, 1'b1); checkOutput("pp_drain_9", 1'b1, 4'h9, 1'b0, 1'b0);
    applyStimulus(4'h0, 1'b1, 1'b1); checkOutput("pp_drain_A", 1'b1, 4'hA, 1'b0, 1'b0);
    applyStimulus(4'h0, 1'b1, 1'b1); checkOutput("pp_drain_empty", 1'b0, 4'h0, 1'b0, 1'b0);
    releaseKey(4, 1'b1);

    // Reset with a queued event while B is held, then B re-debounces once
    pressKey(4'hB, 1'b0, 4'hB, 1'b0, 1'b0, "rst_pre_event");
    applyStimulus(4'hB, 1'b0, 1'b0);
    checkOutput("rst_clears", 1'b0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < DB + 1; i++) begin
      applyStimulus(4'hB, 1'b0, 1'b1);
      checkOutput($sformatf("rst_redebounce%0d", i), 1'b0, 4'h0, 1'b0, 1'b0);
    end
    applyStimulus(4'hB, 1'b0, 1'b1);
    checkOutput("rst_reevent", 1'b1, 4'hB, 1'b0, 1'b0);
    applyStimulus(4'h0, 1'b1, 1'b1);
    checkOutput("rst_reevent_popped", 1'b0, 4'h0, 1'b0, 1'b0);
    releaseKey(8, 1'b1);

    // Reset in the middle of a press debounce leaves no event behind
    for (int i = 0; i < 3; i++) applyStimulus(4'hC, 1'b1, 1'b1);
    applyStimulus(4'h0, 1'b1, 1'b0);
    checkOutput("mid_db_reset", 1'b0, 4'h0, 1'b0, 1'b0);
    ev_count = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'h0, 1'b1, 1'b1);
      if (ev_valid) ev_count++;
    end
    vectors_applied++;
    if (ev_count != 0) begin
      miscompares++;
      $display("[TB] FAIL mid_db_no_event: got %0d events, expected 0", ev_count);
    end

`ifdef KEY_REPEAT_EN
    // Auto-repeat: held 4 repeats every 8 cycles after the first event
    pressKey(4'h4, 1'b1, 4'h4, 1'b0, 1'b0, "rpt_first");
    for (int i = 1; i <= 30; i++) begin
      applyStimulus(4'h4, 1'b1, 1'b1);
      checkOutput($sformatf("rpt_hold%0d", i), (i % 8 == 0), 4'h4, 1'b0, 1'b0);
    end
    applyStimulus(4'h4, 1'b1, 1'b0);
    checkOutput("rpt_reset", 1'b0, 4'h0, 1'b0, 1'b0);
    releaseKey(8, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
